// File: rtl/ram_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port-per-direction RAM.
// The arbiter takes the slave view; a requester/RAM model takes the master view.
interface ram_arbiter_if #(
    parameter int RAM_WIDTH = 64,
    parameter int ADDR_SIZE = 12
);
    logic                 req0;
    logic                 req1;
    logic                 we0;
    logic                 we1;
    logic [ADDR_SIZE-1:0] addr0;
    logic [ADDR_SIZE-1:0] addr1;
    logic [RAM_WIDTH-1:0] wdata0;
    logic [RAM_WIDTH-1:0] wdata1;
    logic                 gnt0;
    logic                 gnt1;
    logic                 rvalid0;
    logic                 rvalid1;
    logic [RAM_WIDTH-1:0] rdata;
    logic [RAM_WIDTH-1:0] ram_data_in;
    logic [ADDR_SIZE-1:0] ram_wr_address;
    logic [ADDR_SIZE-1:0] ram_rd_address;
    logic                 ram_write;
    logic                 ram_read;
    logic [RAM_WIDTH-1:0] ram_data_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
               ram_data_in, ram_wr_address, ram_rd_address, ram_write, ram_read
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
               ram_data_in, ram_wr_address, ram_rd_address, ram_write, ram_read
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester RAM arbiter: independent round-robin write and read classes,
// registered RAM commands, and a read-return pipeline with write-to-read bypass.
module ram_arbiter #(
    parameter int RAM_WIDTH  = 64,
    parameter int ADDR_SIZE  = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    typedef struct packed {
        logic                 vld;
        logic                 id;
        logic                 byp;
        logic [RAM_WIDTH-1:0] bdata;
    } rd_slot_t;

    logic wr_req0, wr_req1, rd_req0, rd_req1;
    logic wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;

    // Id of the requester granted most recently in each class.
    logic wr_last_q, wr_last_d;
    logic rd_last_q, rd_last_d;

    logic                 ram_write_q, ram_write_d;
    logic [ADDR_SIZE-1:0] ram_wr_address_q, ram_wr_address_d;
    logic [RAM_WIDTH-1:0] ram_data_in_q, ram_data_in_d;
    logic                 ram_read_q, ram_read_d;
    logic [ADDR_SIZE-1:0] ram_rd_address_q, ram_rd_address_d;
    logic                 rd_id_q, rd_id_d;

    rd_slot_t             rd_pipe_q [RD_LATENCY];
    rd_slot_t             rd_pipe_d [RD_LATENCY];
    rd_slot_t             rd_entry;
    rd_slot_t             rd_ret;

    logic [RAM_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        wr_req0 = bus.req0 & bus.we0;
        wr_req1 = bus.req1 & bus.we1;
        rd_req0 = bus.req0 & ~bus.we0;
        rd_req1 = bus.req1 & ~bus.we1;

        wr_gnt0 = ~rst & wr_req0 & (~wr_req1 | wr_last_q);
        wr_gnt1 = ~rst & wr_req1 & (~wr_req0 | ~wr_last_q);
        rd_gnt0 = ~rst & rd_req0 & (~rd_req1 | rd_last_q);
        rd_gnt1 = ~rst & rd_req1 & (~rd_req0 | ~rd_last_q);

        wr_last_d = wr_last_q;
        if (wr_gnt1)      wr_last_d = 1'b1;
        else if (wr_gnt0) wr_last_d = 1'b0;

        rd_last_d = rd_last_q;
        if (rd_gnt1)      rd_last_d = 1'b1;
        else if (rd_gnt0) rd_last_d = 1'b0;
    end

    // Command stage: accepted commands become RAM strobes one cycle later.
    always_comb begin
        ram_write_d      = wr_gnt0 | wr_gnt1;
        ram_wr_address_d = ram_wr_address_q;
        ram_data_in_d    = ram_data_in_q;
        if (ram_write_d) begin
            ram_wr_address_d = wr_gnt1 ? bus.addr1  : bus.addr0;
            ram_data_in_d    = wr_gnt1 ? bus.wdata1 : bus.wdata0;
        end

        ram_read_d       = rd_gnt0 | rd_gnt1;
        ram_rd_address_d = ram_rd_address_q;
        rd_id_d          = rd_id_q;
        if (ram_read_d) begin
            ram_rd_address_d = rd_gnt1 ? bus.addr1 : bus.addr0;
            rd_id_d          = rd_gnt1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_last_q        <= 1'b1;
            rd_last_q        <= 1'b1;
            ram_write_q      <= 1'b0;
            ram_wr_address_q <= '0;
            ram_data_in_q    <= '0;
            ram_read_q       <= 1'b0;
            ram_rd_address_q <= '0;
            rd_id_q          <= 1'b0;
            rdata_q          <= '0;
        end else begin
            wr_last_q        <= wr_last_d;
            rd_last_q        <= rd_last_d;
            ram_write_q      <= ram_write_d;
            ram_wr_address_q <= ram_wr_address_d;
            ram_data_in_q    <= ram_data_in_d;
            ram_read_q       <= ram_read_d;
            ram_rd_address_q <= ram_rd_address_d;
            rd_id_q          <= rd_id_d;
            rdata_q          <= rdata_d;
        end
    end

    // Return pipeline: a read issued this cycle carries the colliding write data along.
    always_comb begin
        rd_entry.vld   = ram_read_q;
        rd_entry.id    = rd_id_q;
        rd_entry.byp   = ram_write_q & ram_read_q & (ram_wr_address_q == ram_rd_address_q);
        rd_entry.bdata = ram_data_in_q;
    end

    assign rd_pipe_d[0] = rst ? '0 : rd_entry;

    for (genvar g = 1; g < RD_LATENCY; g++) begin : g_shift
        assign rd_pipe_d[g] = rst ? '0 : rd_pipe_q[g-1];
    end

    always_ff @(posedge clk) begin
        rd_pipe_q <= rd_pipe_d;
    end

    assign rd_ret = rd_pipe_q[RD_LATENCY-1];

    always_comb begin
        rdata_d = rdata_q;
        if (rd_ret.vld) rdata_d = rd_ret.byp ? rd_ret.bdata : bus.ram_data_out;
    end

    assign bus.gnt0           = wr_gnt0 | rd_gnt0;
    assign bus.gnt1           = wr_gnt1 | rd_gnt1;
    assign bus.rvalid0        = rd_ret.vld & ~rd_ret.id;
    assign bus.rvalid1        = rd_ret.vld & rd_ret.id;
    assign bus.rdata          = rdata_d;
    assign bus.ram_write      = ram_write_q;
    assign bus.ram_wr_address = ram_wr_address_q;
    assign bus.ram_data_in    = ram_data_in_q;
    assign bus.ram_read       = ram_read_q;
    assign bus.ram_rd_address = ram_rd_address_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a read-first RAM model of one-cycle latency.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic mem_fill;
    int   total = 0;
    int   bad   = 0;

    logic [63:0] mem [0:4095];

    ram_arbiter_if bus ();

    ram_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 64'hC0DE_0000_0000_0000 | 64'(i);
        end else begin
            if (bus.ram_write) mem[bus.ram_wr_address] <= bus.ram_data_in;
            if (bus.ram_read)  bus.ram_data_out <= mem[bus.ram_rd_address];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.we0    = 1'b0;
        bus.we1    = 1'b0;
        bus.addr0  = '0;
        bus.addr1  = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
    endtask

    initial begin
        rst      = 1'b1;
        mem_fill = 1'b1;
        idle();
        tick();
        mem_fill = 1'b0;

        // write request during reset is neither granted nor issued
        bus.req0 = 1'b1;
        bus.we0  = 1'b1;
        bus.addr0 = 12'h777;
        #1 chk("rst_gnt0", bus.gnt0, 0);
        tick();
        chk("rst_wr", bus.ram_write, 0);
        chk("rst_rd", bus.ram_read, 0);
        chk("rst_rv0", bus.rvalid0, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_wa", bus.ram_wr_address, 0);
        rst = 1'b0;
        idle();

        // inputs of idle requesters are ignored
        bus.we0 = 1'b1; bus.addr0 = 12'h333; bus.wdata0 = '1; bus.addr1 = 12'h444;
        #1 chk("ign_gnt0", bus.gnt0, 0);
        chk("ign_gnt1", bus.gnt1, 0);
        tick();
        chk("ign_wr", bus.ram_write, 0);
        chk("ign_rd", bus.ram_read, 0);
        idle();

        // single write
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 12'h005; bus.wdata0 = 64'hA5A5;
        #1 chk("w1_gnt0", bus.gnt0, 1);
        chk("w1_gnt1", bus.gnt1, 0);
        tick();
        idle();
        chk("w1_wr", bus.ram_write, 1);
        chk("w1_wa", bus.ram_wr_address, 12'h005);
        chk("w1_wd", bus.ram_data_in, 64'hA5A5);
        chk("w1_rd", bus.ram_read, 0);
        tick();
        chk("w1_wr_off", bus.ram_write, 0);

        // write contention after reset alternates 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 12'h010; bus.wdata0 = 64'h1111;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 12'h020; bus.wdata1 = 64'h2222;
        for (int c = 0; c < 4; c++) begin
            logic e0;
            e0 = (c % 2 == 0);
            #1 chk("rr_gnt0", bus.gnt0, e0);
            chk("rr_gnt1", bus.gnt1, !e0);
            tick();
            chk("rr_wa", bus.ram_wr_address, e0 ? 64'h010 : 64'h020);
            chk("rr_wd", bus.ram_data_in, e0 ? 64'h1111 : 64'h2222);
        end
        idle();

        // read from the top address
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 12'hFFF;
        #1 chk("r1_gnt1", bus.gnt1, 1);
        chk("r1_gnt0", bus.gnt0, 0);
        tick();
        idle();
        chk("r1_rd", bus.ram_read, 1);
        chk("r1_ra", bus.ram_rd_address, 12'hFFF);
        chk("r1_rv1_early", bus.rvalid1, 0);
        tick();
        chk("r1_rv1", bus.rvalid1, 1);
        chk("r1_rv0", bus.rvalid0, 0);
        chk("r1_rdata", bus.rdata, 64'hC0DE_0000_0000_0FFF);
        tick();
        chk("r1_rv1_off", bus.rvalid1, 0);
        chk("r1_hold", bus.rdata, 64'hC0DE_0000_0000_0FFF);

        // same-address write/read collision returns the write data
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 12'h100; bus.wdata0 = 64'h1234;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 12'h100;
        #1 chk("byp_gnt0", bus.gnt0, 1);
        chk("byp_gnt1", bus.gnt1, 1);
        tick();
        idle();
        chk("byp_wr", bus.ram_write, 1);
        chk("byp_rd", bus.ram_read, 1);
        chk("byp_ra", bus.ram_rd_address, 12'h100);
        tick();
        chk("byp_rv1", bus.rvalid1, 1);
        chk("byp_rdata", bus.rdata, 64'h1234);

        // read by 0 and write by 1 in the same cycle
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h005;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 12'h200; bus.wdata1 = 64'hBEEF;
        #1 chk("mix_gnt0", bus.gnt0, 1);
        chk("mix_gnt1", bus.gnt1, 1);
        tick();
        idle();
        chk("mix_wa", bus.ram_wr_address, 12'h200);
        chk("mix_ra", bus.ram_rd_address, 12'h005);
        tick();
        chk("mix_rv0", bus.rvalid0, 1);
        chk("mix_rv1", bus.rvalid1, 0);
        chk("mix_rdata", bus.rdata, 64'hA5A5);

        // read contention: requester 0 read last, so 1 wins, then 0 back-to-back
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h010;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 12'h020;
        #1 chk("rc_gnt0", bus.gnt0, 0);
        chk("rc_gnt1", bus.gnt1, 1);
        tick();
        bus.req1 = 1'b0;
        #1 chk("rc_gnt0_b", bus.gnt0, 1);
        chk("rc_ra1", bus.ram_rd_address, 12'h020);
        tick();
        idle();
        chk("rc_rd", bus.ram_read, 1);
        chk("rc_ra0", bus.ram_rd_address, 12'h010);
        chk("rc_rv1", bus.rvalid1, 1);
        chk("rc_rdata1", bus.rdata, 64'h2222);
        tick();
        chk("rc_rv0", bus.rvalid0, 1);
        chk("rc_rv1_off", bus.rvalid1, 0);
        chk("rc_rdata0", bus.rdata, 64'h1111);

        // reset right after a read issue discards it
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h020;
        #1 chk("rd_gnt0", bus.gnt0, 1);
        tick();
        idle();
        rst = 1'b1;
        chk("rd_issue", bus.ram_read, 1);
        tick();
        chk("dis_rv0", bus.rvalid0, 0);
        chk("dis_rv1", bus.rvalid1, 0);
        chk("dis_rd", bus.ram_read, 0);
        chk("dis_wr", bus.ram_write, 0);
        chk("dis_ra", bus.ram_rd_address, 0);
        chk("dis_wa", bus.ram_wr_address, 0);
        chk("dis_wd", bus.ram_data_in, 0);
        chk("dis_rdata", bus.rdata, 0);
        rst = 1'b0;
        tick();
        chk("dis_rv0_late", bus.rvalid0, 0);
        chk("dis_rv1_late", bus.rvalid1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 64, meaning data word width.
REQ-002 SHALL have parameter ADDR_SIZE, default 12, meaning word address width.
REQ-003 SHALL have parameter RD_LATENCY, default 1, meaning cycles from ram_read asserted to ram_data_out valid (range 1-4).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports req0/req1  input  1  requester N command request.
REQ-007 SHALL have ports we0/we1  input  1  requester N command type: 1 = write, 0 = read.
REQ-008 SHALL have ports addr0/addr1  input  ADDR_SIZE  requester N word address.
REQ-009 SHALL have ports wdata0/wdata1  input  RAM_WIDTH  requester N write data.
REQ-010 SHALL have ports gnt0/gnt1  output  1  requester N command accepted this cycle.
REQ-011 SHALL have ports rvalid0/rvalid1  output  1  read data for requester N valid this cycle.
REQ-012 SHALL have port rdata  output  RAM_WIDTH  shared read-return data, qualified by rvalid0/rvalid1.
REQ-013 SHALL have port ram_data_in  output  RAM_WIDTH  RAM write data.
REQ-014 SHALL have port ram_wr_address  output  ADDR_SIZE  RAM write address.
REQ-015 SHALL have port ram_rd_address  output  ADDR_SIZE  RAM read address.
REQ-016 SHALL have port ram_write  output  1  RAM write strobe.
REQ-017 SHALL have port ram_read  output  1  RAM read strobe.
REQ-018 SHALL have port ram_data_out  input  RAM_WIDTH  RAM read data.

Function
REQ-019 SHALL arbitrate the write class (reqN & weN) and the read class (reqN & !weN) independently; at most one write and one read accepted per cycle.
REQ-020 SHALL assert gntN combinationally in cycle T when requester N wins its class; the command is accepted when reqN & gntN; requester holds req/we/addr/wdata stable until accepted.
REQ-021 SHALL resolve contention within a class round-robin: winner is requester not granted most recently in that class; a sole requester always wins; each class pointer updates only on a grant.
REQ-022 SHALL register accepted commands: write accepted in T -> ram_write=1, ram_wr_address, ram_data_in driven in T+1; read accepted in T -> ram_read=1, ram_rd_address driven in T+1; strobes 0 in cycles with no accepted command.
REQ-023 SHALL track each issued read in an RD_LATENCY-deep pipeline of {valid, requester id}; read issued in T+1 returns rdata with rvalidN=1 for exactly one cycle in T+1+RD_LATENCY.
REQ-024 SHALL support back-to-back accepts every cycle per class with no bubbles; returns arrive in issue order.
REQ-025 SHALL bypass same-address collisions: if ram_write and ram_read assert in the same cycle with equal addresses, the returned rdata for that read SHALL equal ram_data_in of that cycle, not ram_data_out.
REQ-026 SHALL hold rdata at its last value when no rvalid is asserted; rvalid0 and rvalid1 never both 1.
REQ-027 SHALL ignore addr/wdata/we of a requester whose req is 0.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, clear gnt0/1 (forced 0 during rst), rvalid0/1, ram_write, ram_read, ram_wr_address, ram_rd_address, ram_data_in, rdata to 0.
REQ-029 SHALL reset both round-robin pointers so requester 0 wins the first contention in each class.
REQ-030 SHALL discard all in-flight reads on reset; no rvalid may assert for a read issued before the reset cycle.

Verification
REQ-031 SHALL cover: req0 write addr 0x005 data 0xA5A5 at T -> gnt0 at T, ram_write=1 addr 0x005 data 0xA5A5 at T+1.
REQ-032 SHALL cover: req0 and req1 both write continuously for 4 cycles after reset -> grants 0,1,0,1; ram_wr_address sequence follows.
REQ-033 SHALL cover: req1 read addr 0xFFF at T, RD_LATENCY=1 -> ram_read at T+1 addr 0xFFF, rvalid1=1 with RAM contents at T+2, rvalid0=0.
REQ-034 SHALL cover: req0 write addr 0x100 data 0x1234 and req1 read addr 0x100 same cycle -> rvalid1 two cycles later with rdata=0x1234 (bypass).
REQ-035 SHALL cover: read accepted at T, rst=1 at T+1 -> no rvalid at T+2 or after; all outputs 0 at T+2.
REQ-036 SHALL cover: req0 read and req1 write same cycle -> both gnt0 and gnt1 asserted that cycle.
